// File: rtl/axi_inst_rom_slave.sv
// AXI4 read-only instruction memory slave: INCR bursts served from a preloadable word array.
// First beat 2+RD_DELAY cycles after AR accept; a 2-entry skid buffer absorbs rready stalls.
module axi_inst_rom_slave #(
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h1FC0_0000,
  parameter int          RD_DELAY   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  mem_we,
  input  logic [DEPTH_LOG2-1:0] mem_waddr,
  input  logic [31:0]           mem_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [31:0] mem_q [2**DEPTH_LOG2];

  state_t      state_q;
  logic        arready_q;
  logic [31:0] base_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic        size_err_q;
  logic        below_q;
  logic        issue_done_q;
  logic [15:0] dly_q;

  logic        rd_vld_q;
  logic        rd_dec_q;
  logic        rd_last_q;
  logic [1:0]  rd_resp_q;
  logic [31:0] rd_dat_q;

  beat_t       slot0_q;
  beat_t       slot1_q;
  logic [1:0]  cnt_q;

  logic        pop;
  logic        rd_en;
  logic        beat_dec;
  logic [31:0] beat_addr;
  logic [1:0]  occ;
  beat_t       fill;

  always_comb begin
    pop       = (cnt_q != 2'd0) && rready;
    beat_addr = base_q + {24'd0, beat_q};
    beat_dec  = below_q || (beat_addr[31:DEPTH_LOG2] != '0);
    // Reads in flight plus buffered beats never exceed the two skid slots.
    occ       = cnt_q + {1'b0, rd_vld_q};
    rd_en     = (state_q == S_BURST) && !issue_done_q && ((occ < 2'd2) || pop);
    fill      = '0;
    fill.dat  = rd_dec_q ? 32'd0 : rd_dat_q;
    fill.resp = rd_resp_q;
    fill.last = rd_last_q;
  end

  // Memory contents survive reset; read-before-write on a shared edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (rd_en)  rd_dat_q <= mem_q[beat_addr[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      arready_q    <= 1'b0;
      base_q       <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      size_err_q   <= 1'b0;
      below_q      <= 1'b0;
      issue_done_q <= 1'b0;
      dly_q        <= '0;
      rd_vld_q     <= 1'b0;
      rd_dec_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_resp_q    <= RESP_OKAY;
      slot0_q      <= '0;
      slot1_q      <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid && arready_q) begin
            base_q       <= (araddr - BASE_ADDR) >> 2;
            len_q        <= arlen;
            size_err_q   <= (arsize != 3'd2);
            below_q      <= (araddr < BASE_ADDR);
            beat_q       <= '0;
            issue_done_q <= 1'b0;
            arready_q    <= 1'b0;
            if (RD_DELAY > 0) begin
              state_q <= S_WAIT;
              dly_q   <= 16'(RD_DELAY - 1);
            end else begin
              state_q <= S_BURST;
            end
          end
        end
        S_WAIT: begin
          if (dly_q == 16'd0) state_q <= S_BURST;
          else                dly_q   <= dly_q - 16'd1;
        end
        S_BURST: begin
          if (rd_en) begin
            beat_q <= beat_q + 8'd1;
            if (beat_q == len_q) issue_done_q <= 1'b1;
          end
          if (pop && slot0_q.last) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      rd_vld_q <= rd_en;
      if (rd_en) begin
        rd_dec_q  <= beat_dec;
        rd_last_q <= (beat_q == len_q);
        rd_resp_q <= beat_dec ? RESP_DECERR : (size_err_q ? RESP_SLVERR : RESP_OKAY);
      end

      case ({pop, rd_vld_q})
        2'b01: begin
          if (cnt_q == 2'd0) slot0_q <= fill;
          else               slot1_q <= fill;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b10: begin
          slot0_q <= slot1_q;
          cnt_q   <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            slot0_q <= fill;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= fill;
          end
        end
        default: ;
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = (cnt_q != 2'd0);
  assign rdata   = slot0_q.dat;
  assign rresp   = slot0_q.resp;
  assign rlast   = slot0_q.last & (cnt_q != 2'd0);

endmodule

// File: tb/tb_axi_inst_rom_slave.sv
// Bench for axi_inst_rom_slave: two instances (RD_DELAY 0 and 3) share inputs, sel picks the one under test.
module tb_axi_inst_rom_slave;

  localparam int          DL    = 8;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1FC0_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [31:0]   araddr = '0;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic          arvalid = 1'b0;
  logic          rready = 1'b0;
  logic          mem_we = 1'b0;
  logic [DL-1:0] mem_waddr = '0;
  logic [31:0]   mem_wdata = '0;
  logic          sel = 1'b0;

  logic        arready0, rlast0, rvalid0, arready1, rlast1, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rresp0, rresp1;

  axi_inst_rom_slave #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .RD_DELAY(0)) u_dut0 (
    .clk(clk), .rst(rst), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid & ~sel), .arready(arready0), .rdata(rdata0), .rresp(rresp0),
    .rlast(rlast0), .rvalid(rvalid0), .rready(rready), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata));

  axi_inst_rom_slave #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .RD_DELAY(3)) u_dut1 (
    .clk(clk), .rst(rst), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid & sel), .arready(arready1), .rdata(rdata1), .rresp(rresp1),
    .rlast(rlast1), .rvalid(rvalid1), .rready(rready), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata));

  logic        o_arready, o_rlast, o_rvalid;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp;
  assign o_arready = sel ? arready1 : arready0;
  assign o_rvalid  = sel ? rvalid1  : rvalid0;
  assign o_rlast   = sel ? rlast1   : rlast0;
  assign o_rdata   = sel ? rdata1   : rdata0;
  assign o_rresp   = sel ? rresp1   : rresp0;

  int cyc = 0;
  int acc_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arvalid && o_arready) acc_cnt <= acc_cnt + 1;
  end

  logic [31:0] model_mem [DEPTH];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic write_word(input int addr, input logic [31:0] dat);
    mem_we    = 1'b1;
    mem_waddr = DL'(addr);
    mem_wdata = dat;
    @(negedge clk);
    mem_we = 1'b0;
    model_mem[addr] = dat;
  endtask

  // mode 0: rready held high, 1: random rready, 2: fixed 1,0,0,1,0,1 pattern.
  task automatic run_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input int mode, input bit hold, input int abort_after);
    logic [31:0] exp_dat [$];
    logic [1:0]  exp_rsp [$];
    logic [31:0] w0, w, hd_dat;
    logic [1:0]  hd_rsp;
    logic        hd_last, held;
    bit          pat [6];
    int n, t_acc, idx, waited, k, d, acc_before;
    bit stop;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    d = sel ? 3 : 0;
    w0 = (addr - BASE) / 4;
    for (int i = 0; i <= len; i++) begin
      w = w0 + i;
      if (addr < BASE || w >= DEPTH) begin
        exp_dat.push_back(32'd0);
        exp_rsp.push_back(2'd3);
      end else begin
        exp_dat.push_back(model_mem[w]);
        exp_rsp.push_back(size != 3'd2 ? 2'd2 : 2'd0);
      end
    end
    acc_before = acc_cnt;
    araddr  = addr;
    arlen   = 8'(len);
    arsize  = size;
    arvalid = 1'b1;
    n = 0;
    while (!o_arready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept_timeout", {31'd0, n >= 200}, 32'd0);
    @(negedge clk);
    t_acc = cyc;
    if (!hold) arvalid = 1'b0;
    idx = 0; waited = 0; held = 1'b0; k = 0; stop = 1'b0;
    hd_dat = '0; hd_rsp = '0; hd_last = 1'b0;
    while (!stop) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom_range(0, 1));
        default: rready = pat[k % 6];
      endcase
      k++;
      if (held) begin
        chk("stall_rvalid", {31'd0, o_rvalid}, 32'd1);
        chk("stall_rdata", o_rdata, hd_dat);
        chk("stall_rresp", {30'd0, o_rresp}, {30'd0, hd_rsp});
        chk("stall_rlast", {31'd0, o_rlast}, {31'd0, hd_last});
      end
      if (o_rvalid) begin
        if (mode == 0) chk("beat_time", cyc, t_acc + 2 + d + idx);
        if (rready) begin
          chk("rdata", o_rdata, exp_dat[idx]);
          chk("rresp", {30'd0, o_rresp}, {30'd0, exp_rsp[idx]});
          chk("rlast", {31'd0, o_rlast}, {31'd0, idx == len});
          idx++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd_dat = o_rdata; hd_rsp = o_rresp; hd_last = o_rlast;
        end
      end else begin
        held = 1'b0;
      end
      @(negedge clk);
      waited++;
      if (idx > len) stop = 1'b1;
      if (abort_after >= 0 && idx >= abort_after) stop = 1'b1;
      if (waited >= 3000) stop = 1'b1;
    end
    if (abort_after < 0 || idx < abort_after) begin
      chk("burst_beats", idx, len + 1);
      if (idx > len) begin
        chk("arready_after_rlast", {31'd0, o_arready}, 32'd1);
        if (hold) chk("one_accept", acc_cnt - acc_before, 1);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arready"}, {31'd0, o_arready}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, o_rvalid}, 32'd0);
    chk({tag, "_rlast"}, {31'd0, o_rlast}, 32'd0);
    chk({tag, "_rresp"}, {30'd0, o_rresp}, 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int len;
    logic [2:0] sz;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("arready_post_reset", {31'd0, o_arready}, 32'd1);

    for (int i = 0; i < DEPTH; i++) write_word(i, $urandom);
    write_word(5, 32'hDEADBEEF);
    for (int i = 8; i < 16; i++) write_word(i, 32'h100 + 32'(i - 8));

    run_burst(BASE + 32'h14, 0, 3'd2, 0, 1'b0, -1);
    run_burst(BASE + 32'h20, 7, 3'd2, 0, 1'b0, -1);
    run_burst(BASE + 32'h20, 7, 3'd2, 2, 1'b0, -1);
    run_burst(BASE + 32'(4 * (DEPTH - 2)), 3, 3'd2, 0, 1'b0, -1);
    run_burst(BASE + 32'h40, 3, 3'd0, 0, 1'b0, -1);
    run_burst(BASE - 32'd16, 1, 3'd2, 1, 1'b0, -1);
    run_burst(BASE, 255, 3'd2, 1, 1'b0, -1);

    for (int t = 0; t < 20; t++) begin
      a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = BASE - 32'($urandom_range(1, 64));
      len = $urandom_range(0, 15);
      sz = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      run_burst(a, len, sz, 1, 1'b0, -1);
    end

    sel = 1'b1;
    run_burst(BASE + 32'h14, 0, 3'd2, 0, 1'b1, -1);
    run_burst(BASE + 32'h20, 3, 3'd2, 0, 1'b1, -1);
    arvalid = 1'b0;
    @(negedge clk);
    sel = 1'b0;

    run_burst(BASE + 32'h20, 7, 3'd2, 0, 1'b0, 2);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    chk("arready_after_mid_reset", {31'd0, o_arready}, 32'd1);
    run_burst(BASE + 32'h20, 7, 3'd2, 0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_inst_rom_slave.md
# axi_inst_rom_slave

AXI4 read-only responder that serves instruction fetches from an on-chip word-addressed memory. It is the slave end of the instruction-cache refill port: it accepts single-beat uncached reads and INCR line bursts on AR, then returns data on R. It is used in the SoC instruction path and as the memory model in cache testbenches. A side write port preloads the memory.

## Interface
- `DEPTH_LOG2`, default 14: memory holds 2^DEPTH_LOG2 32-bit words.
- `BASE_ADDR`, default 32'h1FC0_0000: byte address of word 0.
- `RD_DELAY`, default 0: extra wait cycles inserted before the first beat of every burst. Emulates slow memory.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `araddr` in 32: burst start byte address.
- `arlen` in 8: beats minus 1.
- `arsize` in 3: bytes per beat, log2.
- `arvalid` in 1 / `arready` out 1: AR handshake.
- `rdata` out 32: read data.
- `rresp` out 2: 0 = OKAY, 2 = SLVERR, 3 = DECERR.
- `rlast` out 1: final beat of the burst.
- `rvalid` out 1 / `rready` in 1: R handshake.
- `mem_we` in 1, `mem_waddr` in DEPTH_LOG2, `mem_wdata` in 32: word write port for preload.

## Operation
- **States.**
  - IDLE: `arready` = 1.
  - WAIT: counts RD_DELAY cycles.
  - BURST: streams beats.
  - `arready` = 0 in every state other than IDLE.
- **AR accept.** An address is accepted when `arvalid & arready`. On accept, latch:
  - word address `(araddr - BASE_ADDR) >> 2`; `araddr[1:0]` is ignored.
  - `arlen`.
  - an error flag: set when `arsize != 2`.
- **State transitions.** IDLE goes to WAIT when RD_DELAY > 0, otherwise straight to BURST. WAIT goes to BURST after RD_DELAY cycles.
- **Per-beat address.** Each beat's word address is the start address + beat index, using full 32-bit arithmetic.
- **Per-beat response.** Evaluated in this priority order:
  - Word address ≥ 2^DEPTH_LOG2, or `araddr` < BASE_ADDR: `rresp` = DECERR, `rdata` = 0.
  - Else, if the arsize error flag is set: `rresp` = SLVERR, with real memory data.
  - Else: `rresp` = OKAY.
- **Pipeline.** The memory has a synchronous 1-cycle read. A 2-entry output skid buffer decouples memory reads from `rready`. A memory read is issued only when a buffer slot will be free.
- **rlast.** Asserted exactly on beat `arlen` (0-based beat index). After the `rlast` handshake the block returns to IDLE.
- **Preload port.** `mem_we` writes take effect at the clock edge. A read issued on the same edge returns the old data. Writes are legal during a burst; beats already fetched are not updated.
- **Reset.** Affects only the control logic, not memory contents.

## Timing
- **Reset values.** `arready` = 0, `rvalid` = 0, `rlast` = 0, `rresp` = 0, `rdata` = 0, skid buffer empty, state IDLE. `arready` rises in the first cycle after `rst` deasserts.
- **Reset mid-burst.** Asserting `rst` mid-burst drops `rvalid` on the next edge and abandons the burst; no further beats are produced.
- **Latency.** AR accepted at edge T → first `rvalid` = 1 at T+2+RD_DELAY.
- **Throughput.** With `rready` held high, beats are back-to-back, one per cycle. An N-beat burst completes at T+1+RD_DELAY+N.
- **Back-pressure.** While `rvalid & ~rready`, `rdata`, `rresp` and `rlast` hold stable. `rvalid` never drops until the handshake completes. No beat is lost or duplicated under any `rready` pattern.
- **Back-to-back bursts.** `arready` returns high the cycle after the `rlast` handshake. The earliest next accept is that cycle.
- **Held arvalid.** An `arvalid` held high during a burst is not accepted until IDLE.
- **Wrap-around.** An INCR burst crossing the top of memory gives DECERR on the beats past the end. It does not wrap.
- **arlen range.** `arlen` = 255 is supported: the 8-bit beat counter compares equal on the last beat.

## Test plan
- **Single beat, no delay.** Preload word 5 = 32'hDEADBEEF. AR `araddr` = BASE+0x14, `arlen` = 0, `arsize` = 2, `rready` = 1. Expect at T+2: `rvalid` = 1, `rdata` = DEADBEEF, `rlast` = 1, `rresp` = 0. Expect `arready` = 1 at T+3.
- **8-beat line refill.** Preload words 8..15 = 0x100..0x107. AR at BASE+0x20, `arlen` = 7. Expect `rvalid` continuous T+2..T+9 with data 0x100..0x107 in order, and `rlast` only at T+9.
- **Back-pressure.** Same burst with `rready` = 1,0,0,1,0,1,…. Expect every beat delivered once, in order, and outputs stable across stalled cycles.
- **Error responses.**
  - AR at BASE + 4·(2^DEPTH_LOG2 − 2), `arlen` = 3 → beats 0–1 OKAY, beats 2–3 DECERR with `rdata` 0.
  - `arsize` = 0 → all beats SLVERR.
- **RD_DELAY = 3.** Single beat → `rvalid` at T+5. `arvalid` held high throughout → exactly one accept per burst.
- **Reset mid-burst.** Assert `rst` after beat 2 of 8 → `rvalid` = 0 next cycle and `arready` = 1 after release. A new AR returns correct data with a fresh beat count.
